duty_slew: RTL and testbench
============================

Name: duty_slew

Overview:
Slew-rate limiter sitting between the 4-bit up/down brightness counter and the PDM modulator.
- Takes a target duty (the counter value left-justified into 15 bits) and ramps its output duty toward that target in fixed steps at a fixed tick rate.
- The PDM-driven LED therefore fades smoothly instead of jumping on each button release.
- Reports busy while ramping and pulses settled when the output reaches the target.

Parameters:
WIDTH, 15, bit width of tgt and duty (matches PDM duty input)
PRESCALE, 1024, clocks per ramp tick; legal range 1..65535
STEP, 64, amount duty moves per tick; legal range 1..2^WIDTH-1

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
tgt  input  WIDTH  target duty; may change on any cycle
duty  output  WIDTH  current ramped duty, registered, to PDM
busy  output  1  high while in UP or DN state, registered
settled  output  1  one-clock pulse when duty becomes equal to the registered target, registered
hold  input  1  present only with DUTY_SLEW_HOLD_EN; freezes the ramp

Behaviour:
- Reset (asynchronous, any time including mid-ramp): duty=0, busy=0, settled=0, tgt_q=0, prescaler=0, state=IDLE.
- Target register: tgt_q <= tgt every clock. All comparisons use tgt_q, not tgt.
- Prescaler: counts 0..PRESCALE-1 only in UP/DN. tick asserts when prescaler==PRESCALE-1, then the prescaler wraps to 0. It is cleared to 0 on every state transition. PRESCALE=1 gives a tick every clock.
- States:
  - IDLE: busy=0.
    - tgt_q>duty -> UP.
    - tgt_q<duty -> DN.
    - Otherwise stay in IDLE.
  - UP: busy=1.
    - On tick: duty <= min(duty+STEP, tgt_q). Compute the sum in WIDTH+1 bits; no wrap past 2^WIDTH-1.
  - DN: busy=1.
    - On tick: duty <= max(duty-STEP, tgt_q). Compute in WIDTH+1 bits signed; no wrap below 0.
- Exit checks, evaluated every clock in UP/DN using the next duty value:
  - Next duty == tgt_q -> IDLE, settled=1 for exactly one clock.
  - In UP with tgt_q < next duty -> DN (direction reversal), no settled pulse.
  - In DN with tgt_q > next duty -> UP, no settled pulse.
  - A target change that lands exactly on the current duty with no tick -> IDLE with settled pulse.
- Latency:
  - tgt changes at cycle N -> tgt_q at N+1 -> state UP/DN and busy=1 at N+2.
  - First duty change at N+2+PRESCALE.
  - Full ramp takes ceil(|tgt-duty|/STEP) ticks.
- settled never asserts in IDLE without a preceding UP/DN. It never asserts at reset release.
- duty changes only on tick or reset. It is monotonic within a single UP or DN stretch.

Optional Feature:
DUTY_SLEW_HOLD_EN
- Defined:
  - hold port exists.
  - While hold=1 in UP/DN, the prescaler and duty are frozen and the state is retained. busy stays 1.
  - Target-reached and reversal checks are still evaluated; the settled pulse fires if tgt_q moves onto the frozen duty.
  - Releasing hold resumes counting from the frozen prescaler value.
  - hold has no effect in IDLE.
- Undefined: no hold port; the ramp is never frozen.

Test Plan:
- Parameters WIDTH=15, PRESCALE=4, STEP=512 for all scenarios.
- Reset then tgt=0x7800 -> busy=1 two clocks later; duty steps 0,512,1024,... every 4 clocks; duty=0x7800 after 60 ticks (240 clocks in UP); settled pulses 1 clock; busy=0.
- From duty=0, tgt=1000 -> duty 512 after 1st tick, then 1000 (clamped, not 1024) after 2nd tick; settled pulse; duty never exceeds 1000.
- From settled duty=0x7800, tgt=0 -> DN; duty decrements 512 per tick; reaches 0 with no underflow; settled pulse.
- Reversal: ramping up at duty=2048, tgt changed to 0 -> next clock state DN, prescaler cleared, no settled pulse; next tick duty=1536.
- Async reset asserted mid-ramp at duty=3072 -> duty, busy and settled go to 0 immediately without a clock edge; after release with tgt=0, state stays IDLE and no settled pulse occurs.
- DUTY_SLEW_HOLD_EN: hold=1 for 20 clocks mid-ramp at duty=1024 -> duty holds 1024, busy=1; after release, next step occurs after the remaining prescaler count.

Source files
------------

// File: rtl/duty_slew.sv
// Slew-rate limiter: ramps duty toward a registered target in STEP increments every PRESCALE clocks.
// Optional DUTY_SLEW_HOLD_EN adds a hold input that freezes the ramp while in UP/DN.
module duty_slew #(
  parameter int WIDTH    = 15,
  parameter int PRESCALE = 1024,
  parameter int STEP     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] duty,
  output logic             busy,
  output logic             settled
`ifdef DUTY_SLEW_HOLD_EN
  ,
  input  logic             hold
`endif
);

  typedef enum logic [1:0] {IDLE, UP, DN} state_t;

  localparam logic [15:0]              PS_LAST = 16'(PRESCALE - 1);
  localparam logic signed [WIDTH+1:0]  STEP_S  = (WIDTH + 2)'(STEP);

  // Upward step saturating at the target; the extra bit keeps the sum from wrapping.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] lim);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + STEP_S[WIDTH:0];
    if (sum > {1'b0, lim}) step_up = lim;
    else                   step_up = sum[WIDTH-1:0];
  endfunction

  // Downward step saturating at the target; signed headroom catches underflow below zero.
  function automatic logic [WIDTH-1:0] step_dn(input logic [WIDTH-1:0] cur,
                                               input logic [WIDTH-1:0] lim);
    logic signed [WIDTH+1:0] diff;
    diff = $signed({2'b00, cur}) - STEP_S;
    if (diff < $signed({2'b00, lim})) step_dn = lim;
    else                              step_dn = diff[WIDTH-1:0];
  endfunction

  state_t           state, state_d;
  logic [15:0]      presc, presc_d;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] duty_d;
  logic             settled_d;
  logic             busy_d;
  logic             frozen;

`ifdef DUTY_SLEW_HOLD_EN
  assign frozen = hold;
`else
  assign frozen = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    presc_d   = presc;
    duty_d    = duty;
    settled_d = 1'b0;
    case (state)
      IDLE: begin
        presc_d = '0;
        if (tgt_q > duty)      state_d = UP;
        else if (tgt_q < duty) state_d = DN;
      end
      UP, DN: begin
        if (!frozen) begin
          if (presc == PS_LAST) begin
            presc_d = '0;
            duty_d  = (state == UP) ? step_up(duty, tgt_q) : step_dn(duty, tgt_q);
          end else begin
            presc_d = presc + 16'd1;
          end
        end
        // Exit checks look at the duty value about to be registered.
        if (duty_d == tgt_q) begin
          state_d   = IDLE;
          settled_d = 1'b1;
          presc_d   = '0;
        end else if (state == UP && tgt_q < duty_d) begin
          state_d = DN;
          presc_d = '0;
        end else if (state == DN && tgt_q > duty_d) begin
          state_d = UP;
          presc_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      presc   <= '0;
      tgt_q   <= '0;
      duty    <= '0;
      busy    <= 1'b0;
      settled <= 1'b0;
    end else begin
      state   <= state_d;
      presc   <= presc_d;
      tgt_q   <= tgt;
      duty    <= duty_d;
      busy    <= busy_d;
      settled <= settled_d;
    end
  end

endmodule

// File: tb/tb_duty_slew.sv
// Bench for duty_slew (WIDTH=15, PRESCALE=4, STEP=512): directed scenarios plus random targets
// checked against a behavioural ramp model. Hold scenarios run when DUTY_SLEW_HOLD_EN is defined.
module tb_duty_slew;
  localparam int W = 15;
  localparam int P = 4;
  localparam int S = 512;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] tgt = '0;
  logic         hold_i = 1'b0;
  logic [W-1:0] duty;
  logic         busy;
  logic         settled;

  always #5 clk = ~clk;

  duty_slew #(.WIDTH(W), .PRESCALE(P), .STEP(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tgt     (tgt),
    .duty    (duty),
    .busy    (busy),
    .settled (settled)
`ifdef DUTY_SLEW_HOLD_EN
    ,
    .hold    (hold_i)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: direction (+1 up, -1 down, 0 idle), tick counter, duty, registered target.
  int m_tq, m_dir, m_cnt, m_duty;
  bit m_set;

  task automatic model_reset();
    m_tq = 0; m_dir = 0; m_cnt = 0; m_duty = 0; m_set = 0;
  endtask

  function automatic logic [W+1:0] exp_vec();
    logic [W-1:0] d;
    d = m_duty[W-1:0];
    return {d, (m_dir != 0), m_set};
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic step();
    int nd, nt, want;
    @(posedge clk);
    nt = int'(tgt);
    if (!rst_n) begin
      model_reset();
    end else begin
      nd = m_duty;
      m_set = 0;
      if (m_dir == 0) begin
        if (m_tq > m_duty) m_dir = 1;
        else if (m_tq < m_duty) m_dir = -1;
      end else begin
        if (!hold_i) begin
          if (m_cnt == P - 1) begin
            if (m_dir > 0) nd = (m_duty + S > m_tq) ? m_tq : m_duty + S;
            else           nd = (m_duty - S < m_tq) ? m_tq : m_duty - S;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        if (nd == m_tq) begin
          m_dir = 0; m_cnt = 0; m_set = 1;
        end else begin
          want = (m_tq > nd) ? 1 : -1;
          if (want != m_dir) begin
            m_dir = want; m_cnt = 0;
          end
        end
      end
      m_duty = nd;
      m_tq = nt;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tgt = '0; hold_i = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({duty, busy, settled} !== {15'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got %h exp %h", {duty, busy, settled}, {15'd0, 2'b00});
    end
    for (int c = 0; c < 6; c++) begin
      step();
      vectors++;
      if ({duty, busy, settled} !== exp_vec() || settled !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_release cyc %0d got %h exp %h", c, {duty, busy, settled}, exp_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int set_cyc, set_cnt;
    set_cyc = -1; set_cnt = 0;
    tgt = 15'h7800;
    for (int c = 1; c <= 260; c++) begin
      step();
      vectors++;
      if ({duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL ramp_up cyc %0d got %h exp %h", c, {duty, busy, settled}, exp_vec());
      end
      if (c == 1 && busy !== 1'b0) begin
        miscompares++; $display("FAIL ramp_up_busy_early got %b exp 0", busy);
      end
      if (c == 2) begin
        vectors++;
        if (busy !== 1'b1) begin
          miscompares++; $display("FAIL ramp_up_busy_latency got %b exp 1", busy);
        end
      end
      if (c == 6) begin
        vectors++;
        if (duty !== 15'd512) begin
          miscompares++; $display("FAIL ramp_up_first_step got %0d exp 512", duty);
        end
      end
      if (settled === 1'b1) begin
        set_cnt++;
        if (set_cyc < 0) set_cyc = c;
      end
    end
    vectors++;
    if (set_cyc != 242 || set_cnt != 1 || duty !== 15'h7800 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_up_settle got cyc %0d cnt %0d duty %h busy %b exp cyc 242 cnt 1 duty 7800 busy 0",
               set_cyc, set_cnt, duty, busy);
    end
  endtask

  task automatic test_ramp_down();
    int set_cnt;
    set_cnt = 0;
    tgt = '0;
    for (int c = 1; c <= 260; c++) begin
      step();
      vectors++;
      if ({duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL ramp_down cyc %0d got %h exp %h", c, {duty, busy, settled}, exp_vec());
      end
      if (settled === 1'b1) set_cnt++;
    end
    vectors++;
    if (duty !== 15'd0 || set_cnt != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ramp_down_end got duty %0d cnt %0d busy %b exp duty 0 cnt 1 busy 0", duty, set_cnt, busy);
    end
  endtask

  task automatic test_clamp();
    int set_cyc, max_d;
    set_cyc = -1; max_d = 0;
    tgt = 15'd1000;
    for (int c = 1; c <= 20; c++) begin
      step();
      vectors++;
      if ({duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL clamp cyc %0d got %h exp %h", c, {duty, busy, settled}, exp_vec());
      end
      if (int'(duty) > max_d) max_d = int'(duty);
      if (settled === 1'b1 && set_cyc < 0) set_cyc = c;
      if (c == 6 && duty !== 15'd512) begin
        vectors++; miscompares++;
        $display("FAIL clamp_first_tick got %0d exp 512", duty);
      end
    end
    vectors++;
    if (duty !== 15'd1000 || max_d != 1000 || set_cyc != 10) begin
      miscompares++;
      $display("FAIL clamp_end got duty %0d max %0d settle %0d exp 1000 1000 10", duty, max_d, set_cyc);
    end
  endtask

  task automatic wait_duty(input logic [W-1:0] val, input string name);
    int n;
    n = 0;
    while (duty !== val && n < 80) begin
      step();
      n++;
      vectors++;
      if ({duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL %s cyc %0d got %h exp %h", name, n, {duty, busy, settled}, exp_vec());
      end
    end
    if (duty !== val) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout got %0d exp %0d", name, duty, val);
    end
  endtask

  task automatic test_reversal();
    int chg_cyc, chg_val, set_cnt;
    chg_cyc = -1; chg_val = -1; set_cnt = 0;
    do_reset();
    tgt = 15'h7800;
    wait_duty(15'd2048, "rev_approach");
    tgt = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      vectors++;
      if ({duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL reversal cyc %0d got %h exp %h", c, {duty, busy, settled}, exp_vec());
      end
      if (settled === 1'b1) set_cnt++;
      if (duty !== 15'd2048 && chg_cyc < 0) begin
        chg_cyc = c; chg_val = int'(duty);
      end
    end
    vectors++;
    if (chg_cyc != 6 || chg_val != 1536 || set_cnt != 0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reversal_step got cyc %0d val %0d settled %0d busy %b exp cyc 6 val 1536 settled 0 busy 1",
               chg_cyc, chg_val, set_cnt, busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tgt = 15'h7800;
    wait_duty(15'd3072, "arst_approach");
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({duty, busy, settled} !== {15'd0, 2'b00}) begin
      miscompares++;
      $display("FAIL async_reset got %h exp %h", {duty, busy, settled}, {15'd0, 2'b00});
    end
    model_reset();
    tgt = '0;
    step(); step();
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      vectors++;
      if ({duty, busy, settled} !== {15'd0, 2'b00}) begin
        miscompares++;
        $display("FAIL async_release cyc %0d got %h exp %h", c, {duty, busy, settled}, {15'd0, 2'b00});
      end
    end
  endtask

  task automatic test_random();
    int r, v;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      r = int'($urandom_range(0, 47));
      if (r == 0) begin
        tgt = 15'($urandom_range(0, 32767));
      end else if (r == 1) begin
        tgt = m_duty[W-1:0];
      end else if (r == 2) begin
        v = m_duty + int'($urandom_range(0, 1600)) - 800;
        if (v < 0) v = 0;
        if (v > 32767) v = 32767;
        tgt = v[W-1:0];
      end
`ifdef DUTY_SLEW_HOLD_EN
      if ($urandom_range(0, 15) == 0) hold_i = ~hold_i;
`endif
      step();
      vectors++;
      if ({duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc %0d tgt %h got %h exp %h", c, tgt, {duty, busy, settled}, exp_vec());
      end
    end
    hold_i = 1'b0;
  endtask

`ifdef DUTY_SLEW_HOLD_EN
  task automatic test_hold();
    int n;
    do_reset();
    tgt = 15'h7800;
    wait_duty(15'd1024, "hold_approach");
    step();
    hold_i = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      vectors++;
      if (duty !== 15'd1024 || busy !== 1'b1 || {duty, busy, settled} !== exp_vec()) begin
        miscompares++;
        $display("FAIL hold cyc %0d got %h exp duty 1024 busy 1", c, {duty, busy, settled});
      end
    end
    hold_i = 1'b0;
    n = 0;
    while (duty === 15'd1024 && n < 10) begin
      step();
      n++;
    end
    vectors++;
    if (n != 3 || duty !== 15'd1536) begin
      miscompares++;
      $display("FAIL hold_resume got %0d cycles duty %0d exp 3 cycles duty 1536", n, duty);
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_clamp();
    test_reversal();
    test_async_reset();
`ifdef DUTY_SLEW_HOLD_EN
    test_hold();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
